intra_sad_calc: RTL and testbench

- Upstream neighbour of the intra mode-decision/saver stage.
- For one macroblock, accepts original pixels and every candidate intra prediction, one MB row per cycle.
- Produces per-mode signed residues and per-mode SAD, then pulses enable so the downstream stage can select the minimum-SAD mode and store its residues.
- Output array shapes match the downstream stage's sads/allresidues inputs.

---
 rtl/intra_sad_calc.sv | 127 ++++++++++++
 tb/tb_intra_sad_calc.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intra_sad_calc.sv
// Per-mode residue and SAD calculator for one intra macroblock, one row per cycle.
// Pulses enable for one cycle once every row has been folded into the SAD totals.
module intra_sad_calc #(
  parameter int unsigned MB_SIZE_L = 8,
  parameter int unsigned MB_SIZE_W = 8,
  parameter int unsigned NUM_MODES = (MB_SIZE_L == 4) ? 8 : 3
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic [31:0]                                  mbnumber_in,
  input  logic                                         row_valid,
  output logic                                         row_ready,
  input  logic [8*MB_SIZE_W-1:0]                       orig_row,
  input  logic [NUM_MODES*MB_SIZE_W*8-1:0]             pred_rows,
  output logic [NUM_MODES*8-1:0]                       sads,
  output logic [NUM_MODES*MB_SIZE_L*MB_SIZE_W*8-1:0]   allresidues,
  output logic [31:0]                                  mbnumber,
  output logic                                         enable,
  output logic                                         busy
);

  localparam int unsigned RW = (MB_SIZE_L > 1) ? $clog2(MB_SIZE_L) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(MB_SIZE_L - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e                                       state_q;
  logic [RW-1:0]                                row_cnt_q;
  logic [31:0]                                  id_q;
  logic [31:0]                                  mbnumber_q;
  logic [14:0]                                  acc_q [NUM_MODES];
  logic [14:0]                                  acc_d [NUM_MODES];
  logic [NUM_MODES*8-1:0]                       sads_q;
  logic [NUM_MODES*8-1:0]                       sads_d;
  logic [NUM_MODES*MB_SIZE_L*MB_SIZE_W*8-1:0]   res_q;
  logic signed [8:0]                            diff [NUM_MODES][MB_SIZE_W];
  logic [8:0]                                   mag  [NUM_MODES][MB_SIZE_W];
  logic [7:0]                                   res_d [NUM_MODES][MB_SIZE_W];
  logic                                         enable_q;
  logic                                         row_ready_q;
  logic                                         busy_q;
  logic                                         accept;

  assign accept = (state_q == ACCUM) && row_valid && row_ready_q;

  // SAD uses the full 9-bit magnitude; only the stored residue is clipped.
  always_comb begin
    sads_d = '0;
    for (int unsigned m = 0; m < NUM_MODES; m++) begin
      acc_d[m] = acc_q[m];
      for (int unsigned c = 0; c < MB_SIZE_W; c++) begin
        diff[m][c] = $signed({1'b0, orig_row[c*8 +: 8]})
                   - $signed({1'b0, pred_rows[(m*MB_SIZE_W + c)*8 +: 8]});
        mag[m][c]  = diff[m][c][8] ? 9'(-diff[m][c]) : 9'(diff[m][c]);
        if (diff[m][c] > 9'sd127)
          res_d[m][c] = 8'h7F;
        else if (diff[m][c] < -9'sd128)
          res_d[m][c] = 8'h80;
        else
          res_d[m][c] = diff[m][c][7:0];
        acc_d[m] = acc_d[m] + {6'd0, mag[m][c]};
      end
      sads_d[m*8 +: 8] = (acc_d[m] > 15'd255) ? 8'hFF : acc_d[m][7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      id_q        <= '0;
      mbnumber_q  <= '0;
      sads_q      <= '0;
      res_q       <= '0;
      enable_q    <= 1'b0;
      row_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned m = 0; m < NUM_MODES; m++) acc_q[m] <= '0;
    end else begin
      enable_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= ACCUM;
            id_q        <= mbnumber_in;
            row_cnt_q   <= '0;
            row_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            for (int unsigned m = 0; m < NUM_MODES; m++) acc_q[m] <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            for (int unsigned m = 0; m < NUM_MODES; m++) begin
              acc_q[m] <= acc_d[m];
              for (int unsigned c = 0; c < MB_SIZE_W; c++)
                res_q[((m*MB_SIZE_L + 32'(row_cnt_q))*MB_SIZE_W + c)*8 +: 8] <= res_d[m][c];
            end
            row_cnt_q <= row_cnt_q + RW'(1);
            // Results are registered from the next-state totals so they line up with enable.
            if (row_cnt_q == LAST_ROW) begin
              state_q     <= DONE;
              row_ready_q <= 1'b0;
              enable_q    <= 1'b1;
              sads_q      <= sads_d;
              mbnumber_q  <= id_q;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign row_ready   = row_ready_q;
  assign sads        = sads_q;
  assign allresidues = res_q;
  assign mbnumber    = mbnumber_q;
  assign enable      = enable_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_intra_sad_calc.sv
// Scoreboard bench for intra_sad_calc: expected MB results are queued when an MB
// is driven and compared against the outputs whenever enable pulses.
module tb_intra_sad_calc;
  localparam int L   = 8;
  localparam int W   = 8;
  localparam int M   = 3;
  localparam int SW  = M*8;
  localparam int RSW = M*L*W*8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [31:0]    mbnumber_in = '0;
  logic           row_valid = 1'b0;
  logic           row_ready;
  logic [8*W-1:0] orig_row = '0;
  logic [M*W*8-1:0] pred_rows = '0;
  logic [SW-1:0]  sads;
  logic [RSW-1:0] allresidues;
  logic [31:0]    mbnumber;
  logic           enable;
  logic           busy;

  intra_sad_calc #(.MB_SIZE_L(L), .MB_SIZE_W(W), .NUM_MODES(M)) dut (
    .clk(clk), .reset(reset), .start(start), .mbnumber_in(mbnumber_in),
    .row_valid(row_valid), .row_ready(row_ready), .orig_row(orig_row),
    .pred_rows(pred_rows), .sads(sads), .allresidues(allresidues),
    .mbnumber(mbnumber), .enable(enable), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]    id;
    logic [SW-1:0]  sads;
    logic [RSW-1:0] res;
  } exp_t;

  logic [7:0] cur_orig [L][W];
  logic [7:0] cur_pred [M][L][W];
  exp_t exp_q[$];
  int   en_cyc_q[$];
  int   en_count = 0;
  logic prev_en = 1'b0;
  int   last_row_cyc = 0;
  int   start_cyc = 0;

  function automatic exp_t model(input logic [31:0] id);
    exp_t e;
    int d, sad, rs;
    e.id = id; e.sads = '0; e.res = '0;
    for (int m = 0; m < M; m++) begin
      sad = 0;
      for (int r = 0; r < L; r++)
        for (int c = 0; c < W; c++) begin
          d = int'(cur_orig[r][c]) - int'(cur_pred[m][r][c]);
          sad += (d < 0) ? -d : d;
          rs = (d > 127) ? 127 : ((d < -128) ? -128 : d);
          e.res[((m*L + r)*W + c)*8 +: 8] = 8'(rs);
        end
      e.sads[m*8 +: 8] = 8'((sad > 255) ? 255 : sad);
    end
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    int bad;
    if (enable) begin
      en_count++;
      en_cyc_q.push_back(cyc);
      tests_run++;
      if (prev_en) begin
        tests_failed++;
        $display("FAIL enable_width: enable high %0d consecutive cycles, required 1", 2);
      end
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_enable: enable=1 with no MB pending, required 0");
      end else begin
        e = exp_q.pop_front();
        tests_run++;
        if (mbnumber !== e.id) begin
          tests_failed++;
          $display("FAIL mbnumber: got %h, expected %h", mbnumber, e.id);
        end
        tests_run++;
        if (sads !== e.sads) begin
          tests_failed++;
          $display("FAIL sads: mb=%h got %h, expected %h", e.id, sads, e.sads);
        end
        bad = -1;
        for (int i = 0; i < M*L*W; i++)
          if (bad < 0 && allresidues[i*8 +: 8] !== e.res[i*8 +: 8]) bad = i;
        tests_run++;
        if (bad >= 0) begin
          tests_failed++;
          $display("FAIL residues: mb=%h idx=%0d got %h, expected %h",
                   e.id, bad, allresidues[bad*8 +: 8], e.res[bad*8 +: 8]);
        end
      end
    end
    prev_en = enable;
  end

  task automatic set_uniform(input logic [7:0] o, input logic [7:0] p0,
                             input logic [7:0] p1, input logic [7:0] p2);
    for (int r = 0; r < L; r++)
      for (int c = 0; c < W; c++) begin
        cur_orig[r][c] = o;
        cur_pred[0][r][c] = p0;
        cur_pred[1][r][c] = p1;
        cur_pred[2][r][c] = p2;
      end
  endtask

  task automatic set_sat();
    for (int r = 0; r < L; r++)
      for (int c = 0; c < W; c++) begin
        cur_orig[r][c]    = (c % 2 == 0) ? 8'd200 : 8'd0;
        cur_pred[0][r][c] = 8'd0;
        cur_pred[1][r][c] = 8'd255;
        cur_pred[2][r][c] = cur_orig[r][c];
      end
  endtask

  task automatic set_random();
    for (int r = 0; r < L; r++)
      for (int c = 0; c < W; c++) begin
        cur_orig[r][c] = 8'($urandom_range(255));
        for (int m = 0; m < M; m++) cur_pred[m][r][c] = 8'($urandom_range(255));
      end
  endtask

  task automatic drive_row(input int r, output bit ok);
    int n;
    for (int c = 0; c < W; c++) begin
      orig_row[c*8 +: 8] = cur_orig[r][c];
      for (int m = 0; m < M; m++) pred_rows[(m*W + c)*8 +: 8] = cur_pred[m][r][c];
    end
    row_valid = 1'b1;
    n = 0;
    while (!row_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!row_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL row_ready_timeout: row %0d row_ready=%b, required 1", r, row_ready);
      row_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk); #1;
    last_row_cyc = cyc;
    ok = 1'b1;
  endtask

  task automatic run_mb(input logic [31:0] id, input int stall_at, input int stall_n,
                        input int inject_at, input bit hold);
    int n;
    bit ok;
    exp_q.push_back(model(id));
    mbnumber_in = id;
    start = 1'b1;
    n = 0;
    while (!row_ready && n < 30) begin @(posedge clk); #1; n++; end
    if (!row_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL start_timeout: row_ready=%b, required 1", row_ready);
      start = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    start_cyc = cyc;
    if (!hold) start = 1'b0;
    for (int r = 0; r < L; r++) begin
      if (r == stall_at) begin
        row_valid = 1'b0;
        repeat (stall_n) begin
          @(posedge clk); #1;
          tests_run++;
          if (!(row_ready && busy && !enable)) begin
            tests_failed++;
            $display("FAIL stall_hold: ready=%b busy=%b enable=%b, required 1 1 0",
                     row_ready, busy, enable);
          end
        end
      end
      if (r == inject_at) begin
        start = 1'b1;
        mbnumber_in = 32'hDEAD_BEEF;
      end
      drive_row(r, ok);
      if (r == inject_at) start = 1'b0;
      if (!ok) return;
    end
    row_valid = 1'b0;
  endtask

  task automatic wait_enable(input int target);
    int n;
    n = 0;
    while (en_count < target && n < 40) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (en_count < target) begin
      tests_failed++;
      $display("FAIL enable_timeout: pulses seen %0d, required %0d", en_count, target);
    end
  endtask

  task automatic check_zero(input string tag);
    tests_run++;
    if (sads !== '0 || allresidues !== '0 || mbnumber !== '0) begin
      tests_failed++;
      $display("FAIL %s_data: sads=%h mbnumber=%h res_nonzero=%b, required all 0",
               tag, sads, mbnumber, |allresidues);
    end
    tests_run++;
    if (enable !== 1'b0 || row_ready !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_ctrl: enable=%b row_ready=%b busy=%b, required 0 0 0",
               tag, enable, row_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int base, e;
    base = en_count;
    set_uniform(8'd100, 8'd100, 8'd98, 8'd103);
    run_mb(32'h0002_0005, -1, 0, -1, 1'b0);
    wait_enable(base + 1);
    e = en_cyc_q[en_cyc_q.size()-1];
    tests_run++;
    if (e != last_row_cyc || e - start_cyc != L) begin
      tests_failed++;
      $display("FAIL basic_latency: enable at %0d (last row %0d, start %0d), required %0d",
               e, last_row_cyc, start_cyc, start_cyc + L);
    end
    tests_run++;
    if (sads !== {8'd192, 8'd128, 8'd0}) begin
      tests_failed++;
      $display("FAIL basic_sads: got %h, expected c08000", sads);
    end
    tests_run++;
    if (allresidues[(1*L*W + 0)*8 +: 8] !== 8'h02 || allresidues[(2*L*W + 63)*8 +: 8] !== 8'hFD) begin
      tests_failed++;
      $display("FAIL basic_residue: mode1=%h mode2=%h, required 02 fd",
               allresidues[(1*L*W)*8 +: 8], allresidues[(2*L*W + 63)*8 +: 8]);
    end
    @(posedge clk); #1;
    tests_run++;
    if (enable !== 1'b0 || mbnumber !== 32'h0002_0005) begin
      tests_failed++;
      $display("FAIL basic_hold: enable=%b mbnumber=%h, required 0 00020005", enable, mbnumber);
    end
  endtask

  task automatic test_saturation();
    int base;
    base = en_count;
    set_sat();
    run_mb(32'h0003_0001, -1, 0, -1, 1'b0);
    wait_enable(base + 1);
    tests_run++;
    if (allresidues[7:0] !== 8'h7F || allresidues[(1*L*W + 1)*8 +: 8] !== 8'h80) begin
      tests_failed++;
      $display("FAIL sat_residue: pos=%h neg=%h, required 7f 80",
               allresidues[7:0], allresidues[(1*L*W + 1)*8 +: 8]);
    end
    tests_run++;
    if (sads[7:0] !== 8'hFF) begin
      tests_failed++;
      $display("FAIL sat_sad: got %h, expected ff", sads[7:0]);
    end
  endtask

  task automatic test_stall();
    int base, e;
    base = en_count;
    set_uniform(8'd100, 8'd100, 8'd98, 8'd103);
    run_mb(32'h0002_0006, 4, 3, -1, 1'b0);
    wait_enable(base + 1);
    e = en_cyc_q[en_cyc_q.size()-1];
    tests_run++;
    if (e - start_cyc != L + 3) begin
      tests_failed++;
      $display("FAIL stall_latency: got %0d cycles, required %0d", e - start_cyc, L + 3);
    end
  endtask

  task automatic test_protocol();
    int base;
    base = en_count;
    set_random();
    for (int i = 0; i < 3; i++) begin
      orig_row = {W{8'hA5}};
      row_valid = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (row_ready !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_row_valid: row_ready=%b busy=%b, required 0 0", row_ready, busy);
      end
    end
    row_valid = 1'b0;
    set_uniform(8'd50, 8'd60, 8'd40, 8'd50);
    run_mb(32'h0004_0007, -1, 0, 3, 1'b0);
    wait_enable(base + 1);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (en_count != base + 1 || busy !== 1'b0 || mbnumber !== 32'h0004_0007) begin
      tests_failed++;
      $display("FAIL proto_start: pulses=%0d busy=%b mbnumber=%h, required %0d 0 00040007",
               en_count - base, busy, mbnumber, 1);
    end
  endtask

  task automatic test_async_reset();
    int base, n;
    bit ok;
    base = en_count;
    set_random();
    mbnumber_in = 32'h0005_0005;
    start = 1'b1;
    n = 0;
    while (!row_ready && n < 30) begin @(posedge clk); #1; n++; end
    start = 1'b0;
    for (int r = 0; r < 3; r++) drive_row(r, ok);
    #3;
    reset = 1'b0;
    row_valid = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (en_count != base) begin
      tests_failed++;
      $display("FAIL abort_enable: pulses=%0d, required 0", en_count - base);
    end
    set_uniform(8'd10, 8'd20, 8'd5, 8'd10);
    run_mb(32'h0006_0001, -1, 0, -1, 1'b0);
    wait_enable(base + 1);
  endtask

  task automatic test_back_to_back();
    int base, sz;
    base = en_count;
    set_uniform(8'd30, 8'd30, 8'd31, 8'd29);
    run_mb(32'h0007_0001, -1, 0, -1, 1'b1);
    set_random();
    run_mb(32'h0007_0002, -1, 0, -1, 1'b0);
    wait_enable(base + 2);
    sz = en_cyc_q.size();
    tests_run++;
    if (en_count != base + 2 || en_cyc_q[sz-1] - en_cyc_q[sz-2] != L + 2) begin
      tests_failed++;
      $display("FAIL b2b_gap: pulses=%0d gap=%0d, required 2 %0d",
               en_count - base, en_cyc_q[sz-1] - en_cyc_q[sz-2], L + 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_stall();
    test_protocol();
    test_async_reset();
    test_back_to_back();
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL pending_results: %0d MBs without enable, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
